// File: rtl/four_bit_uni_bus_if.sv
// four_bit_uni_bus_if: source-side word/enable, shared tri-state bus and monitor taps
interface four_bit_uni_bus_if #(parameter int WIDTH = 4);
  logic [WIDTH-1:0] inp;
  logic c;
  tri [WIDTH-1:0] op;
  logic [WIDTH-1:0] last_q;
  logic drv_q;
  modport master(output inp, c, input last_q, drv_q, inout op);
  modport slave(input inp, c, output op, last_q, drv_q);
endinterface

// File: rtl/four_bit_uni_bus.sv
// four_bit_uni_bus: tri-state bus driver with a clocked record of the last driven word
module four_bit_uni_bus #(parameter int WIDTH = 4) (
  input logic clk,
  input logic rst_n,
  four_bit_uni_bus_if.slave bus
);
  // An unknown enable merges inp with Z, so op goes X instead of driving stale data.
  assign bus.op = (rst_n && bus.c) ? bus.inp : {WIDTH{1'bz}};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      bus.last_q <= '0;
      bus.drv_q <= 1'b0;
    end else begin
      bus.drv_q <= bus.c;
      if (bus.c) bus.last_q <= bus.inp;
    end
endmodule

// File: tb/tb_four_bit_uni_bus.sv
// tb_four_bit_uni_bus: directed and random checks of bus drive/release and monitor registers
module tb_four_bit_uni_bus;
  logic clk = 1'b0;
  logic rst_n;
  logic tb_en = 1'b0;
  logic [3:0] tb_val = 4'h0;
  logic [3:0] exp_last = 4'h0;
  logic exp_drv = 1'b0;
  int vectors = 0;
  int miscompares = 0;

  four_bit_uni_bus_if #(.WIDTH(4)) ifc();
  four_bit_uni_bus #(.WIDTH(4)) dut(.clk(clk), .rst_n(rst_n), .bus(ifc));

  // A second source on the shared segment: when the DUT has released the bus,
  // this driver's random word must appear unaltered.
  assign ifc.op = tb_en ? tb_val : 4'bzzzz;

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $display("FAIL %s observed=%b expected=%b", tag, obs, exp);
      $error("%s", tag);
    end
  endtask

  task automatic chk_bus(input string tag);
    if (rst_n === 1'b1 && ifc.c === 1'b1) begin
      tb_en = 1'b0;
      #1;
      chk(tag, ifc.op, ifc.inp);
    end else begin
      tb_val = 4'($urandom);
      tb_en = 1'b1;
      #1;
      chk({tag, "_released"}, ifc.op, tb_val);
      tb_en = 1'b0;
    end
  endtask

  task automatic chk_mon(input string tag);
    chk({tag, "_last_q"}, ifc.last_q, exp_last);
    chk({tag, "_drv_q"}, {3'b000, ifc.drv_q}, {3'b000, exp_drv});
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n === 1'b1) begin
      exp_drv = ifc.c;
      if (ifc.c) exp_last = ifc.inp;
    end
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    exp_last = 4'h0;
    exp_drv = 1'b0;
  endtask

  initial begin
    do_reset();
    ifc.c = 1'b1;
    ifc.inp = 4'hA;
    tick();
    chk_bus("reset_bus");
    chk_mon("reset");
    rst_n = 1'b1;
    for (int v = 0; v < 16; v++) begin
      ifc.inp = 4'(v);
      ifc.c = 1'b0;
      chk_bus("sweep_off");
      repeat (10) tick();
      chk_mon("sweep_off");
      ifc.c = 1'b1;
      chk_bus("sweep_on");
      repeat (10) tick();
      chk_mon("sweep_on");
      ifc.c = 1'b0;
      chk_bus("sweep_off2");
    end
    ifc.c = 1'b1;
    ifc.inp = 4'h5;
    tick();
    chk("mon_capture_last_q", ifc.last_q, 4'h5);
    chk("mon_capture_drv_q", {3'b000, ifc.drv_q}, 4'h1);
    ifc.c = 1'b0;
    ifc.inp = 4'h9;
    tick();
    chk("mon_hold_last_q", ifc.last_q, 4'h5);
    chk("mon_hold_drv_q", {3'b000, ifc.drv_q}, 4'h0);
    ifc.c = 1'b1;
    ifc.inp = 4'hF;
    chk_bus("comb_f");
    ifc.inp = 4'h0;
    chk_bus("comb_0");
    ifc.inp = 4'h7;
    tick();
    chk_mon("pre_reset");
    do_reset();
    chk_bus("async_rst_bus");
    chk("async_rst_last_q", ifc.last_q, 4'h0);
    chk("async_rst_drv_q", {3'b000, ifc.drv_q}, 4'h0);
    ifc.inp = 4'h3;
    rst_n = 1'b1;
    chk_bus("release_bus");
    chk_mon("release_pre_edge");
    tick();
    chk("release_last_q", ifc.last_q, 4'h3);
    chk_mon("release_post_edge");
    repeat (300) begin
      ifc.inp = 4'($urandom);
      ifc.c = 1'($urandom);
      if ($urandom_range(0, 15) == 0) begin
        do_reset();
        chk_bus("rand_rst_bus");
        chk_mon("rand_rst");
        rst_n = 1'b1;
      end
      chk_bus("rand_bus");
      tick();
      chk_mon("rand");
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
